vliw_wb_stage: RTL and testbench

VLIW_WB_STAGE -- requirements
Module: vliw_wb_stage

---
 rtl/vliw_pkg.sv | 21 ++
 rtl/wb_bundle_fifo.sv | 65 ++++++
 rtl/vliw_wb_stage.sv | 132 +++++++++++++
 tb/tb_vliw_wb_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vliw_pkg.sv
// vliw_pkg
//   Shared definitions for the VLIW writeback stage.
//   DATA_W / NUM_REGS are the default register width and register count;
//   REG_ADDR_W is fixed at 5 (32 architectural register names).
//   wb_bundle_t is the two-slot writeback bundle at the default data width.
package vliw_pkg;

  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  s1Valid;
    logic [REG_ADDR_W-1:0] s1Rd;
    logic [DATA_W-1:0]     s1Data;
    logic                  s2Valid;
    logic [REG_ADDR_W-1:0] s2Rd;
    logic [DATA_W-1:0]     s2Data;
  } wb_bundle_t;

endpackage

// File: rtl/wb_bundle_fifo.sv
// wb_bundle_fifo
//   Small circular buffer holding writeback bundles between issue and the
//   register-file write port.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push, pop       enqueue wrData / dequeue head (ignored when full / empty)
//   flush           empties the buffer; wins over push and pop
//   wrData          incoming bundle
//   rdData          current head (valid while count != 0)
//   count           number of buffered entries
module wb_bundle_fifo
  import vliw_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doWrite;
  logic             doRead;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign doWrite = push && !flush && (count < CNT_W'(DEPTH));
  assign doRead  = pop && !flush && (count != '0);
  assign rdData  = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem[wrPtr] <= wrData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= nextPtr(wrPtr);
      if (doRead)  rdPtr <= nextPtr(rdPtr);
      case ({doWrite, doRead})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vliw_wb_stage.sv
// vliw_wb_stage
//   Writeback stage for a two-slot VLIW core. Bundles are buffered, then the
//   head is decoded into per-register write selects and registered onto the
//   register-file port. Writes to r0 are dropped; when both slots target the
//   same register, slot 2 (later in program order) supplies the data.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   s1_*/s2_*                     per-slot valid, destination, result
//   in_ready                      buffer has room; bundle accepted when high
//   stall                         hold writeback (no pop)
//   flush                         drop buffered and incoming bundles
//   regWrite1/2, writeData_1/2    per-slot write enable and data
//   decOut                        per-register write select bitmap
//   writeData_sel                 per-register slot select (1 = slot 2)
//   wb_count                      saturating count of register writes
module vliw_wb_stage
  import vliw_pkg::*;
#(
  parameter int DATA_W   = vliw_pkg::DATA_W,
  parameter int NUM_REGS = vliw_pkg::NUM_REGS,
  parameter int DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s1_valid,
  input  logic                  s2_valid,
  input  logic [4:0]            s1_rd,
  input  logic [4:0]            s2_rd,
  input  logic [DATA_W-1:0]     s1_data,
  input  logic [DATA_W-1:0]     s2_data,
  output logic                  in_ready,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  regWrite1,
  output logic                  regWrite2,
  output logic [DATA_W-1:0]     writeData_1,
  output logic [DATA_W-1:0]     writeData_2,
  output logic [NUM_REGS-1:0]   decOut,
  output logic [NUM_REGS-1:0]   writeData_sel,
  output logic [15:0]           wb_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [NUM_REGS-1:0] REG_ONE = NUM_REGS'(1);

  // Same layout as wb_bundle_t, but sized by this instance's DATA_W.
  typedef struct packed {
    logic                  s1Valid;
    logic [REG_ADDR_W-1:0] s1Rd;
    logic [DATA_W-1:0]     s1Data;
    logic                  s2Valid;
    logic [REG_ADDR_W-1:0] s2Rd;
    logic [DATA_W-1:0]     s2Data;
  } bundleT;

  bundleT              inBundle;
  bundleT              headBundle;
  logic [CNT_W-1:0]    fifoCount;
  logic                fifoEmpty;
  logic                doPush;
  logic                doPop;
  logic                rw1Next;
  logic                rw2Next;
  logic [NUM_REGS-1:0] oh1;
  logic [NUM_REGS-1:0] oh2;
  logic [NUM_REGS-1:0] decNext;
  logic [NUM_REGS-1:0] selNext;
  logic [16:0]         wbSum;

  assign inBundle = '{s1Valid: s1_valid, s1Rd: s1_rd, s1Data: s1_data,
                      s2Valid: s2_valid, s2Rd: s2_rd, s2Data: s2_data};

  // in_ready depends only on the buffer occupancy register, so a full
  // buffer never passes a bundle straight through even while popping.
  assign in_ready  = fifoCount < CNT_W'(DEPTH);
  assign fifoEmpty = fifoCount == '0;
  assign doPush    = in_ready && (s1_valid || s2_valid) && !flush;
  assign doPop     = !stall && !fifoEmpty && !flush;

  wb_bundle_fifo #(
    .WIDTH ($bits(bundleT)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (doPush),
    .pop    (doPop),
    .flush  (flush),
    .wrData (inBundle),
    .rdData (headBundle),
    .count  (fifoCount)
  );

  always_comb begin
    rw1Next = headBundle.s1Valid && (headBundle.s1Rd != '0);
    rw2Next = headBundle.s2Valid && (headBundle.s2Rd != '0);
    oh1     = REG_ONE << headBundle.s1Rd;
    oh2     = REG_ONE << headBundle.s2Rd;
    decNext = ({NUM_REGS{rw1Next}} & oh1) | ({NUM_REGS{rw2Next}} & oh2);
    // Slot 2 owns any register it writes, which also settles a same-rd clash.
    selNext = {NUM_REGS{rw2Next}} & oh2;
    // A same-rd pair collapses to one bit in decNext, so it counts once.
    wbSum   = {1'b0, wb_count} + 17'($countones(decNext));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite1     <= 1'b0;
      regWrite2     <= 1'b0;
      writeData_1   <= '0;
      writeData_2   <= '0;
      decOut        <= '0;
      writeData_sel <= '0;
      wb_count      <= '0;
    end else if (doPop) begin
      regWrite1     <= rw1Next;
      regWrite2     <= rw2Next;
      writeData_1   <= headBundle.s1Data;
      writeData_2   <= headBundle.s2Data;
      decOut        <= decNext;
      writeData_sel <= selNext;
      wb_count      <= wbSum[16] ? 16'hFFFF : wbSum[15:0];
    end else begin
      // Stall, empty or flush: drop the enables, keep the data lines steady.
      regWrite1     <= 1'b0;
      regWrite2     <= 1'b0;
      decOut        <= '0;
      writeData_sel <= '0;
    end
  end

endmodule

// File: tb/tb_vliw_wb_stage.sv
// tb_vliw_wb_stage
//   Directed bench for vliw_wb_stage. Each accepted bundle pushes its
//   expected register-file transaction onto a scoreboard queue; output
//   cycles pop and compare. wb_count is tracked by a saturating model.
module tb_vliw_wb_stage;
  import vliw_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                s1_valid, s2_valid;
  logic [4:0]          s1_rd, s2_rd;
  logic [31:0]         s1_data, s2_data;
  logic                in_ready;
  logic                stall, flush;
  logic                regWrite1, regWrite2;
  logic [31:0]         writeData_1, writeData_2;
  logic [31:0]         decOut, writeData_sel;
  logic [15:0]         wb_count;

  typedef struct {
    logic        rw1;
    logic        rw2;
    logic [31:0] wd1;
    logic [31:0] wd2;
    logic [31:0] dec;
    logic [31:0] sel;
  } expT;

  expT         sbQ[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] expWb = '0;

  vliw_wb_stage #(.DATA_W(32), .NUM_REGS(32), .DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .s1_valid      (s1_valid),
    .s2_valid      (s2_valid),
    .s1_rd         (s1_rd),
    .s2_rd         (s2_rd),
    .s1_data       (s1_data),
    .s2_data       (s2_data),
    .in_ready      (in_ready),
    .stall         (stall),
    .flush         (flush),
    .regWrite1     (regWrite1),
    .regWrite2     (regWrite2),
    .writeData_1   (writeData_1),
    .writeData_2   (writeData_2),
    .decOut        (decOut),
    .writeData_sel (writeData_sel),
    .wb_count      (wb_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                       input logic v2, input logic [4:0] rd2, input logic [31:0] d2,
                       input logic accepted);
    expT         e;
    logic [31:0] one;
    one = 32'd1;
    s1_valid = v1; s1_rd = rd1; s1_data = d1;
    s2_valid = v2; s2_rd = rd2; s2_data = d2;
    if (accepted) begin
      e.rw1 = v1 && (rd1 != 5'd0);
      e.rw2 = v2 && (rd2 != 5'd0);
      e.wd1 = d1;
      e.wd2 = d2;
      e.dec = (e.rw1 ? (one << rd1) : 32'd0) | (e.rw2 ? (one << rd2) : 32'd0);
      e.sel = e.rw2 ? (one << rd2) : 32'd0;
      sbQ.push_back(e);
    end
  endtask

  task automatic idleIn();
    s1_valid = 1'b0;
    s2_valid = 1'b0;
  endtask

  task automatic checkOut(input string tag);
    expT e;
    int  sum;
    check({tag, "_sb_nonempty"}, 64'(sbQ.size() != 0), 64'd1);
    if (sbQ.size() == 0) return;
    e   = sbQ.pop_front();
    sum = int'(expWb) + $countones(e.dec);
    expWb = (sum > 65535) ? 16'hFFFF : 16'(sum);
    check({tag, "_regWrite1"},     64'(regWrite1),     64'(e.rw1));
    check({tag, "_regWrite2"},     64'(regWrite2),     64'(e.rw2));
    check({tag, "_writeData_1"},   64'(writeData_1),   64'(e.wd1));
    check({tag, "_writeData_2"},   64'(writeData_2),   64'(e.wd2));
    check({tag, "_decOut"},        64'(decOut),        64'(e.dec));
    check({tag, "_writeData_sel"}, 64'(writeData_sel), 64'(e.sel));
    check({tag, "_wb_count"},      64'(wb_count),      64'(expWb));
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_regWrite1"},     64'(regWrite1),     64'd0);
    check({tag, "_regWrite2"},     64'(regWrite2),     64'd0);
    check({tag, "_decOut"},        64'(decOut),        64'd0);
    check({tag, "_writeData_sel"}, 64'(writeData_sel), 64'd0);
    check({tag, "_wb_count"},      64'(wb_count),      64'(expWb));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    s1_valid = 1'b0; s2_valid = 1'b0;
    s1_rd = '0; s2_rd = '0; s1_data = '0; s2_data = '0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_writeData_1", 64'(writeData_1), 64'd0);
    check("rst_writeData_2", 64'(writeData_2), 64'd0);
    checkIdle("rst");

    // two slots, distinct registers; two-edge latency
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd7, 32'h0000_1234, 1'b1);
    tick();
    idleIn();
    check("single_in_ready", 64'(in_ready), 64'd1);
    check("single_not_early", 64'(regWrite1), 64'd0);
    tick();
    checkOut("single");
    tick();
    checkIdle("single_drain");
    check("single_hold_data", 64'(writeData_1), 64'hDEADBEEF);

    // same rd in both slots: slot 2 wins, counted once
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b1);
    tick();
    idleIn();
    tick();
    checkOut("same_rd");

    // write to r0 is dropped but the bundle still pops
    drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd9, 32'h66, 1'b1);
    tick();
    idleIn();
    tick();
    checkOut("rd0");

    // stall four edges with three push attempts
    stall = 1'b1;
    drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 1'b1);
    tick();
    check("stall_ready_1", 64'(in_ready), 64'd1);
    drive(1'b1, 5'd10, 32'hB1, 1'b1, 5'd0, 32'hB2, 1'b1);
    tick();
    check("stall_ready_full", 64'(in_ready), 64'd0);
    drive(1'b1, 5'd20, 32'hC1, 1'b1, 5'd21, 32'hC2, 1'b0);
    tick();
    check("stall_reject_ready", 64'(in_ready), 64'd0);
    idleIn();
    tick();
    checkIdle("stall_hold");
    stall = 1'b0;
    tick();
    checkOut("release_first");
    check("release_ready", 64'(in_ready), 64'd1);
    tick();
    checkOut("release_second");
    tick();
    checkIdle("release_drain");

    // flush with full buffer and a concurrent push
    stall = 1'b1;
    drive(1'b1, 5'd4, 32'hD1, 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    drive(1'b1, 5'd6, 32'hD2, 1'b1, 5'd8, 32'hD3, 1'b1);
    tick();
    check("flush_pre_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 5'd11, 32'hE1, 1'b1, 5'd12, 32'hE2, 1'b0);
    tick();
    flush = 1'b0;
    idleIn();
    sbQ.delete();
    check("flush_in_ready", 64'(in_ready), 64'd1);
    checkIdle("flush_out");
    stall = 1'b0;
    tick();
    checkIdle("flush_after_1");
    tick();
    checkIdle("flush_after_2");

    // flush overrides a pending pop while outputs are active
    stall = 1'b1;
    drive(1'b1, 5'd13, 32'hF1, 1'b1, 5'd14, 32'hF2, 1'b1);
    tick();
    drive(1'b1, 5'd15, 32'hF3, 1'b1, 5'd16, 32'hF4, 1'b1);
    tick();
    idleIn();
    stall = 1'b0;
    tick();
    checkOut("flush2_first");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sbQ.delete();
    checkIdle("flush2_out");
    tick();
    checkIdle("flush2_after");
    check("flush2_in_ready", 64'(in_ready), 64'd1);

    // reset with one buffered bundle
    drive(1'b1, 5'd17, 32'h77, 1'b1, 5'd18, 32'h88, 1'b1);
    tick();
    idleIn();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sbQ.delete();
    expWb = '0;
    checkIdle("reset_mid");
    check("reset_mid_in_ready", 64'(in_ready), 64'd1);
    tick();
    checkIdle("reset_mid_after");

    // streaming one bundle per cycle until wb_count saturates
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0);
    for (int i = 0; i < 100; i++) tick();
    check("stream_wb_count_mid", 64'(wb_count), 64'd198);
    for (int i = 0; i < 32800; i++) tick();
    idleIn();
    tick();
    tick();
    expWb = 16'hFFFF;
    check("sat_wb_count", 64'(wb_count), 64'hFFFF);
    checkIdle("sat_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
